boot_loader_ctrl: RTL and testbench

Boot sequencer between the UART receiver and instruction memory. It parses a framed byte stream (sync, word count, little-endian payload words, optional checksum) and packs the payload into 32-bit words. Each word is written to consecutive IMEM addresses starting at 0. The CPU is held in reset until a complete, valid image has been loaded.

---
 rtl/boot_pkg.sv | 23 ++
 rtl/boot_timeout.sv | 34 +++
 rtl/boot_loader_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding, sync byte,
// word width and the payload checksum step.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } boot_state_t;

  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;
  localparam int         BOOT_WORD_W    = 32;

  // 8-bit wrapping sum step used by the payload checksum.
  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte watchdog: counts idle clocks while enabled, clears on every kick,
// and flags expiry when the count reaches TIMEOUT_CLKS-1.
module boot_timeout #(
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_r;

  // Idle counter; held at zero whenever the watchdog is not armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!enable || kick) begin
      cnt_r <= '0;
    end else if (cnt_r != TERM) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A byte arriving on the terminal cycle wins over expiry.
  assign expired = enable && !kick && (cnt_r == TERM);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: parses A5/LEN/payload[/CHK] frames from the UART and writes packed
// words to IMEM from address 0. Optional trailing checksum enabled by BOOT_CHECKSUM_EN.
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter  int IMEM_DEPTH   = 1024,
  parameter  int TIMEOUT_CLKS = 10_000_000,
  localparam int ADDR_WIDTH   = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [BOOT_WORD_W-1:0] imem_wdata,
  output logic                   cpu_rst_n,
  output logic                   boot_done,
  output logic                   boot_err
);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t POST_PAYLOAD = CHECK;
`else
  localparam boot_state_t POST_PAYLOAD = DONE;
`endif

  boot_state_t                   state_r, state_nxt_s;
  logic [15:0]                   len_r;
  logic [1:0]                    byte_cnt_r;
  logic [15:0]                   word_cnt_r;
  logic [23:0]                   word_r;
  logic                          imem_we_r;
  logic [ADDR_WIDTH-1:0]         imem_addr_r;
  logic [BOOT_WORD_W-1:0]        imem_wdata_r;
  logic                          done_r, cpu_rst_n_r, err_r;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]                    sum_r;
`endif

  logic        sync_byte_s, sync_accept_s, data_byte_s, wr_s, last_word_s;
  logic        oversize_s, tmo_en_s, expired_s;
  logic [15:0] len_full_s;

  assign sync_byte_s   = rx_valid && (rx_data == BOOT_SYNC_BYTE);
  assign sync_accept_s = sync_byte_s && ((state_r == IDLE) || (state_r == ERROR));
  assign data_byte_s   = rx_valid && (state_r == DATA);
  assign wr_s          = data_byte_s && (byte_cnt_r == 2'd3);
  assign last_word_s   = wr_s && (word_cnt_r == (len_r - 16'd1));
  assign len_full_s    = {rx_data, len_r[7:0]};
  assign oversize_s    = {16'd0, len_full_s} > 32'(IMEM_DEPTH);
  assign tmo_en_s      = (state_r == LEN_LO) || (state_r == LEN_HI) ||
                         (state_r == DATA)   || (state_r == CHECK);

  boot_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (tmo_en_s),
    .kick    (rx_valid),
    .expired (expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a watchdog expiry takes priority in every armed state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sync_byte_s) state_nxt_s = LEN_LO;
        else             state_nxt_s = IDLE;
      end
      LEN_LO: begin
        if (expired_s)     state_nxt_s = ERROR;
        else if (rx_valid) state_nxt_s = LEN_HI;
        else               state_nxt_s = LEN_LO;
      end
      LEN_HI: begin
        if (expired_s) begin
          state_nxt_s = ERROR;
        end else if (rx_valid) begin
          if (oversize_s)                state_nxt_s = ERROR;
          else if (len_full_s == 16'd0)  state_nxt_s = POST_PAYLOAD;
          else                           state_nxt_s = DATA;
        end else begin
          state_nxt_s = LEN_HI;
        end
      end
      DATA: begin
        if (expired_s)        state_nxt_s = ERROR;
        else if (last_word_s) state_nxt_s = POST_PAYLOAD;
        else                  state_nxt_s = DATA;
      end
      CHECK: begin
`ifdef BOOT_CHECKSUM_EN
        if (expired_s)     state_nxt_s = ERROR;
        else if (rx_valid) state_nxt_s = (rx_data == sum_r) ? DONE : ERROR;
        else               state_nxt_s = CHECK;
`else
        state_nxt_s = ERROR;
`endif
      end
      DONE:    state_nxt_s = DONE;
      ERROR: begin
        if (sync_byte_s) state_nxt_s = LEN_LO;
        else             state_nxt_s = ERROR;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Length latch, byte packer, counters and IMEM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r        <= 16'd0;
      byte_cnt_r   <= 2'd0;
      word_cnt_r   <= 16'd0;
      word_r       <= 24'd0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= '0;
    end else begin
      imem_we_r <= wr_s;
      if (wr_s) imem_wdata_r <= {rx_data, word_r};
      if (rx_valid && (state_r == LEN_LO)) len_r[7:0]  <= rx_data;
      if (rx_valid && (state_r == LEN_HI)) len_r[15:8] <= rx_data;
      if (sync_accept_s) begin
        imem_addr_r <= '0;
        byte_cnt_r  <= 2'd0;
        word_cnt_r  <= 16'd0;
      end else begin
        // Address advances the cycle after the strobe so it is stable during the write.
        if (imem_we_r) imem_addr_r <= imem_addr_r + ADDR_WIDTH'(1);
        if (data_byte_s) begin
          byte_cnt_r <= byte_cnt_r + 2'd1;
          word_r     <= {rx_data, word_r[23:8]};
          if (wr_s) word_cnt_r <= word_cnt_r + 16'd1;
        end
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running payload checksum, restarted by every accepted sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= 8'd0;
    end else if (sync_accept_s) begin
      sum_r <= 8'd0;
    end else if (data_byte_s) begin
      sum_r <= chk_add(sum_r, rx_data);
    end else begin
      sum_r <= sum_r;
    end
  end
`endif

  // Status flags follow the next state so they rise one cycle after the deciding byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r      <= 1'b0;
      cpu_rst_n_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r      <= (state_nxt_s == DONE);
      cpu_rst_n_r <= (state_nxt_s == DONE);
      err_r       <= (state_nxt_s == ERROR);
    end
  end

  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign boot_done  = done_r;
  assign cpu_rst_n  = cpu_rst_n_r;
  assign boot_err   = err_r;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: a frame-level model predicts IMEM writes and
// the final outcome; a negedge monitor checks every write strobe against the queue.
module tb_boot_loader_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 100;
  localparam int AW    = 2;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int R_PEND = 0;
  localparam int R_DONE = 1;
  localparam int R_ERR  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n, boot_done, boot_err;

  boot_loader_ctrl #(.IMEM_DEPTH(DEPTH), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest predicted write, on the predicted cycle.
  always @(negedge clk) begin
    if (rst_n && imem_we === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, imem_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {30'd0, imem_addr}, e.addr);
        check("write_data", imem_wdata, e.data);
        check("write_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_we",    {31'd0, imem_we}, 32'd0);
    check("rst_addr",  {30'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu",   {31'd0, cpu_rst_n}, 32'd0);
    check("rst_done",  {31'd0, boot_done}, 32'd0);
    check("rst_err",   {31'd0, boot_err}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic end_test();
    idle(2);
    check("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic build_frame(input int len, input bit corrupt, output logic [7:0] fr[$]);
    logic [7:0] sum;
    logic [7:0] b;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(len[7:0]);
    fr.push_back(len[15:8]);
    sum = 8'd0;
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom);
      sum += b;
      fr.push_back(b);
    end
    if (CHK_EN) fr.push_back(corrupt ? sum + 8'($urandom_range(1, 255)) : sum);
  endtask

  // Frame-level model: length, word count and checksum decide writes and outcome.
  task automatic send_frame(input logic [7:0] fr[$], input int nsend, input bit gaps, output int res);
    int len, nw, need;
    logic [7:0] sum;
    len = 0;
    nw  = 0;
    res = R_PEND;
    if (nsend >= 3) len = int'(fr[1]) + 256 * int'(fr[2]);
    if (nsend >= 3 && len > DEPTH) begin
      res = R_ERR;
    end else if (nsend >= 3) begin
      nw = (nsend - 3) / 4;
      if (nw > len) nw = len;
      need = 3 + 4 * len + (CHK_EN ? 1 : 0);
      if (nsend >= need) begin
        if (CHK_EN) begin
          sum = 8'd0;
          for (int i = 0; i < 4 * len; i++) sum += fr[3 + i];
          res = (fr[3 + 4 * len] == sum) ? R_DONE : R_ERR;
        end else begin
          res = R_DONE;
        end
      end
    end
    for (int j = 0; j < nsend; j++) begin
      if (gaps) idle($urandom_range(0, 2));
      if (j == nsend - 1 && j > 0) begin
        check("early_done", {31'd0, boot_done}, 32'd0);
        check("early_err",  {31'd0, boot_err}, 32'd0);
      end
      if (j >= 3 && (j - 3) < 4 * nw && ((j - 3) % 4) == 3) begin
        wr_t e;
        e.addr = (j - 3) / 4;
        e.data = {fr[j], fr[j-1], fr[j-2], fr[j-3]};
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
      send_byte(fr[j]);
      if (j == 0) check("sync_clears_err", {31'd0, boot_err}, 32'd0);
    end
    if (res != R_PEND) begin
      check("frame_done", {31'd0, boot_done}, {31'd0, res == R_DONE});
      check("frame_err",  {31'd0, boot_err},  {31'd0, res == R_ERR});
      check("frame_cpu",  {31'd0, cpu_rst_n}, {31'd0, res == R_DONE});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] nb;
    int res, len, kind;

    do_reset();

    // Directed good frame, then bytes after DONE must be ignored.
    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    if (CHK_EN) fr.push_back(8'h4C);
    send_frame(fr, fr.size(), 1'b0, res);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'h11);
    idle(2);
    check("done_sticky", {31'd0, boot_done}, 32'd1);
    check("done_no_err", {31'd0, boot_err}, 32'd0);
    end_test();

    // Bad checksum, then the good frame recovers.
    do_reset();
    if (CHK_EN) begin
      fr[11] = 8'h4D;
      send_frame(fr, fr.size(), 1'b0, res);
      idle(3);
      fr[11] = 8'h4C;
    end
    send_frame(fr, fr.size(), 1'b0, res);
    end_test();

    // Zero length.
    do_reset();
    build_frame(0, 1'b0, fr);
    send_frame(fr, fr.size(), 1'b0, res);
    end_test();

    // Oversize length.
    do_reset();
    fr = '{8'hA5, 8'h05, 8'h00};
    send_frame(fr, 3, 1'b0, res);
    end_test();

    // Timeout after the first payload byte.
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_frame(fr, 4, 1'b0, res);
    idle(TMO - 1);
    check("tmo_not_early", {31'd0, boot_err}, 32'd0);
    idle(1);
    check("tmo_err", {31'd0, boot_err}, 32'd1);
    check("tmo_cpu", {31'd0, cpu_rst_n}, 32'd0);
    end_test();

    // Noise before a good frame.
    do_reset();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    build_frame(2, 1'b0, fr);
    send_frame(fr, fr.size(), 1'b0, res);
    end_test();

    // Reset after two payload words, then a fresh load from address 0.
    do_reset();
    build_frame(3, 1'b0, fr);
    send_frame(fr, 11, 1'b0, res);
    idle(2);
    check("pre_reset_writes", exp_q.size(), 32'd0);
    do_reset();
    build_frame(3, 1'b0, fr);
    send_frame(fr, fr.size(), 1'b0, res);
    end_test();

    // Randomized frames: noise, optional failing frame, then a good frame.
    for (int it = 0; it < 40; it++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h00;
        send_byte(nb);
      end
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        len = $urandom_range(DEPTH + 1, 600);
        build_frame(0, 1'b0, fr);
        fr[1] = len[7:0];
        fr[2] = len[15:8];
        send_frame(fr, 3, 1'b1, res);
        idle($urandom_range(0, 3));
      end else if (kind == 2 && CHK_EN) begin
        build_frame($urandom_range(0, DEPTH), 1'b1, fr);
        send_frame(fr, fr.size(), 1'b1, res);
        idle($urandom_range(0, 3));
      end
      build_frame($urandom_range(0, DEPTH), 1'b0, fr);
      send_frame(fr, fr.size(), 1'b1, res);
      end_test();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
